// File: rtl/ray_inverse_sched.sv
// Schedules three reciprocal divisions (1/x, 1/y, 1/z) per ray on a shared
// divider and collects the in-order results into one output beat.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready.
module ray_inverse_sched #(
  parameter logic signed [17:0] DIVIDEND_ONE = 18'sd1,
  parameter int                 WAIT_MAX     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [27:0] dir_x,
  input  logic signed [27:0] dir_y,
  input  logic signed [27:0] dir_z,
  output logic               div_clk_en,
  output logic               div_divisor_tvalid,
  output logic               div_dividend_tvalid,
  output logic signed [27:0] div_divisor,
  output logic signed [17:0] div_dividend,
  input  logic               div_tvalid,
  input  logic               div_by_zero,
  input  logic signed [35:0] div_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [35:0] inv_x,
  output logic signed [35:0] inv_y,
  output logic signed [35:0] inv_z,
  output logic [2:0]         dz_flags,
  output logic               err,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  localparam logic [7:0]         WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic signed [35:0] SAT_POS   = 36'sh7FFFFFFFF;

  state_t             state_q;
  state_t             state_d;
  logic               run_q;
  logic signed [27:0] dir_y_q;
  logic signed [27:0] dir_z_q;
  logic [1:0]         issue_q;
  logic [1:0]         res_cnt_q;
  logic [7:0]         wait_q;
  logic               in_hs;
  logic               beat_ok;
  logic               beat_last;
  logic               timeout;

  always_comb begin
    in_ready            = run_q && (state_q == IDLE);
    out_valid           = (state_q == OUT);
    div_clk_en          = run_q;
    div_divisor_tvalid  = (state_q == ISSUE);
    div_dividend_tvalid = (state_q == ISSUE);
    dbg_state           = state_q;
    in_hs               = in_valid && in_ready;
    // Results may overtake the issue phase, so ISSUE also accepts beats.
    beat_ok             = div_tvalid && ((state_q == ISSUE) || (state_q == WAIT));
    beat_last           = beat_ok && (res_cnt_q == 2'd2);
    timeout             = (state_q == WAIT) && !div_tvalid && (wait_q == WAIT_LAST);
    state_d             = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = ISSUE;
      ISSUE:   begin
                 if (beat_last)              state_d = OUT;
                 else if (issue_q == 2'd2)   state_d = WAIT;
               end
      WAIT:    if (beat_last || timeout) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      div_divisor  <= '0;
      div_dividend <= '0;
      dir_y_q      <= '0;
      dir_z_q      <= '0;
      issue_q      <= '0;
      res_cnt_q    <= '0;
      wait_q       <= '0;
      inv_x        <= '0;
      inv_y        <= '0;
      inv_z        <= '0;
      dz_flags     <= '0;
      err          <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;

      // The x divisor is loaded at accept so it is on the bus in the first issue cycle.
      if (in_hs) begin
        div_divisor  <= dir_x;
        div_dividend <= DIVIDEND_ONE;
        dir_y_q      <= dir_y;
        dir_z_q      <= dir_z;
        issue_q      <= '0;
        res_cnt_q    <= '0;
        wait_q       <= '0;
      end

      if (state_q == ISSUE) begin
        issue_q <= issue_q + 2'd1;
        case (issue_q)
          2'd0:    div_divisor <= dir_y_q;
          2'd1:    div_divisor <= dir_z_q;
          default: ;
        endcase
      end

      if (state_q == WAIT) wait_q <= div_tvalid ? 8'd0 : wait_q + 8'd1;

      if (beat_ok) begin
        res_cnt_q <= res_cnt_q + 2'd1;
        case (res_cnt_q)
          2'd0: begin
            inv_x       <= div_by_zero ? SAT_POS : div_result;
            dz_flags[0] <= div_by_zero;
          end
          2'd1: begin
            inv_y       <= div_by_zero ? SAT_POS : div_result;
            dz_flags[1] <= div_by_zero;
          end
          default: begin
            inv_z       <= div_by_zero ? SAT_POS : div_result;
            dz_flags[2] <= div_by_zero;
          end
        endcase
      end

      // Axes the divider never answered are reported as zero.
      if (timeout) begin
        err <= 1'b1;
        if (res_cnt_q == 2'd0) begin
          inv_x       <= '0;
          dz_flags[0] <= 1'b0;
        end
        if (res_cnt_q <= 2'd1) begin
          inv_y       <= '0;
          dz_flags[1] <= 1'b0;
        end
        inv_z       <= '0;
        dz_flags[2] <= 1'b0;
      end

      if (div_tvalid && !beat_ok) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ray_inverse_sched.sv
// Bench for ray_inverse_sched: divider model with configurable latency, a
// cycle-level reference model checked every cycle, and directed ray scenarios.
module tb_ray_inverse_sched;

  localparam logic signed [17:0] ONE  = 18'sd1;
  localparam int                 WMAX = 64;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [27:0] dir_x;
  logic signed [27:0] dir_y;
  logic signed [27:0] dir_z;
  logic               div_clk_en;
  logic               div_divisor_tvalid;
  logic               div_dividend_tvalid;
  logic signed [27:0] div_divisor;
  logic signed [17:0] div_dividend;
  logic               div_tvalid;
  logic               div_by_zero;
  logic signed [35:0] div_result;
  logic               out_valid;
  logic               out_ready;
  logic signed [35:0] inv_x;
  logic signed [35:0] inv_y;
  logic signed [35:0] inv_z;
  logic [2:0]         dz_flags;
  logic               err;
  logic [1:0]         dbg_state;

  ray_inverse_sched #(.DIVIDEND_ONE(ONE), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
    .div_clk_en(div_clk_en), .div_divisor_tvalid(div_divisor_tvalid),
    .div_dividend_tvalid(div_dividend_tvalid), .div_divisor(div_divisor),
    .div_dividend(div_dividend), .div_tvalid(div_tvalid), .div_by_zero(div_by_zero),
    .div_result(div_result), .out_valid(out_valid), .out_ready(out_ready),
    .inv_x(inv_x), .inv_y(inv_y), .inv_z(inv_z), .dz_flags(dz_flags),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- divider model ----------------
  typedef struct {
    int                 due;
    logic signed [35:0] res;
    logic               dz;
  } beat_t;

  beat_t dq[$];
  int    lat        = 8;
  bit    drop_third = 0;
  bit    spurious   = 0;
  int    strobe_n   = 0;

  function automatic logic signed [35:0] div_fn(input logic signed [17:0] n,
                                                input logic signed [27:0] d);
    longint num;
    num = longint'(n) * 64'sd262144;
    return 36'(num / longint'(d));
  endfunction

  initial begin
    beat_t b;
    div_tvalid  = 1'b0;
    div_by_zero = 1'b0;
    div_result  = '0;
    forever begin
      @(posedge clk);
      #2;
      div_tvalid  = 1'b0;
      div_by_zero = 1'b0;
      div_result  = '0;
      if (!rst_n) begin
        dq.delete();
        strobe_n = 0;
      end else begin
        if (div_divisor_tvalid && div_dividend_tvalid) begin
          if (!(drop_third && (strobe_n % 3 == 2))) begin
            b.due = cyc + lat;
            b.dz  = (div_divisor == 0);
            b.res = b.dz ? 36'sd0 : div_fn(div_dividend, div_divisor);
            dq.push_back(b);
          end
          strobe_n++;
        end
        if (dq.size() > 0 && dq[0].due <= cyc) begin
          b = dq.pop_front();
          div_tvalid  = 1'b1;
          div_by_zero = b.dz;
          div_result  = b.res;
        end else if (spurious) begin
          div_tvalid = 1'b1;
          div_result = 36'sd12345;
          spurious   = 0;
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit                 live;
  bit                 busy;
  bit                 outp;
  int                 acc;
  int                 nres;
  int                 last_act;
  logic signed [27:0] dirs[3];
  logic signed [35:0] m_inv[3];
  logic [2:0]         m_dz;
  logic               m_err;
  logic signed [27:0] m_dsr;
  logic signed [17:0] m_dvd;

  task automatic reset_model();
    busy  = 0;
    outp  = 0;
    nres  = 0;
    for (int i = 0; i < 3; i++) m_inv[i] = '0;
    m_dz  = '0;
    m_err = 1'b0;
    m_dsr = '0;
    m_dvd = '0;
  endtask

  initial begin
    bit e_in_ready;
    bit e_strobe;
    bit was_out;
    live = 0;
    reset_model();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reset_model();
        live = 0;
      end
      e_in_ready = live && !busy;
      e_strobe   = busy && (cyc >= acc + 1) && (cyc <= acc + 3);
      if (e_strobe) begin
        m_dsr = dirs[cyc - acc - 1];
        m_dvd = ONE;
      end
      check("in_ready",     in_ready,            e_in_ready);
      check("out_valid",    out_valid,           busy && outp);
      check("div_clk_en",   div_clk_en,          live);
      check("divisor_tv",   div_divisor_tvalid,  e_strobe);
      check("dividend_tv",  div_dividend_tvalid, e_strobe);
      check("div_divisor",  div_divisor,         m_dsr);
      check("div_dividend", div_dividend,        m_dvd);
      check("inv_x",        inv_x,               m_inv[0]);
      check("inv_y",        inv_y,               m_inv[1]);
      check("inv_z",        inv_z,               m_inv[2]);
      check("dz_flags",     dz_flags,            m_dz);
      check("err",          err,                 m_err);

      if (rst_n) begin
        was_out = outp;
        live    = 1;
        if (div_tvalid) begin
          if (busy && !was_out) begin
            m_inv[nres] = div_by_zero ? 36'sh7FFFFFFFF : div_result;
            m_dz[nres]  = div_by_zero;
            nres++;
            if (cyc > last_act) last_act = cyc;
            if (nres == 3) outp = 1;
          end else begin
            m_err = 1'b1;
          end
        end else if (busy && !was_out && cyc == last_act + WMAX) begin
          m_err = 1'b1;
          for (int i = nres; i < 3; i++) begin
            m_inv[i] = '0;
            m_dz[i]  = 1'b0;
          end
          outp = 1;
        end
        if (busy && was_out && out_ready) begin
          busy = 0;
          outp = 0;
        end
        if (e_in_ready && in_valid) begin
          busy     = 1;
          outp     = 0;
          acc      = cyc;
          nres     = 0;
          last_act = cyc + 3;
          dirs[0]  = dir_x;
          dirs[1]  = dir_y;
          dirs[2]  = dir_z;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_ray(input logic signed [27:0] x, input logic signed [27:0] y,
                          input logic signed [27:0] z, output int a);
    bit got;
    got = 0;
    a   = -1;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    dir_x    = x;
    dir_y    = y;
    dir_z    = z;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        a   = cyc;
      end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int oc);
    bit got;
    got = 0;
    oc  = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        oc  = cyc;
      end
    end
    if (!got) check("out_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int a;
    int oc;
    logic signed [35:0] e36;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dir_x     = '0;
    dir_y     = '0;
    dir_z     = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic ray, divider latency 8
    send_ray(28'sd2, 28'sd4, -28'sd8, a);
    wait_out(oc);
    check("t1_latency", 64'(oc - a), 64'd12);
    e36 = 36'sd131072;  check("t1_inv_x", inv_x, e36);
    e36 = 36'sd65536;   check("t1_inv_y", inv_y, e36);
    e36 = -36'sd32768;  check("t1_inv_z", inv_z, e36);
    check("t1_dz", dz_flags, 3'b000);
    check("t1_err", err, 1'b0);

    // Zero components saturate and flag
    send_ray(28'sd0, 28'sd5, 28'sd0, a);
    wait_out(oc);
    e36 = 36'sh7FFFFFFFF; check("t2_inv_x", inv_x, e36);
    e36 = 36'sd52428;     check("t2_inv_y", inv_y, e36);
    e36 = 36'sh7FFFFFFFF; check("t2_inv_z", inv_z, e36);
    check("t2_dz", dz_flags, 3'b101);

    // Output backpressure
    @(posedge clk);
    #2 out_ready = 1'b0;
    send_ray(28'sd7, -28'sd3, 28'sd1, a);
    wait_out(oc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_valid", out_valid, 1'b1);
      check("t3_hold_ready", in_ready, 1'b0);
      e36 = 36'sd37449; check("t3_hold_inv_x", inv_x, e36);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;

    // Divider loses the third result
    drop_third = 1;
    send_ray(28'sd1, 28'sd2, 28'sd3, a);
    wait_out(oc);
    check("t4_timeout_cycle", 64'(oc - a), 64'(10 + WMAX + 1));
    check("t4_err", err, 1'b1);
    e36 = 36'sd262144; check("t4_inv_x", inv_x, e36);
    e36 = 36'sd131072; check("t4_inv_y", inv_y, e36);
    e36 = 36'sd0;      check("t4_inv_z", inv_z, e36);
    check("t4_dz", dz_flags, 3'b000);
    @(posedge clk);
    #2 drop_third = 0;

    // Reset while waiting on the divider
    send_ray(28'sd4, 28'sd4, 28'sd4, a);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_in_ready", in_ready, 1'b0);
    check("t6_rst_err", err, 1'b0);
    check("t6_rst_clk_en", div_clk_en, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_ready_after_release", in_ready, 1'b1);

    // Spurious result in IDLE, then a clean ray
    @(posedge clk);
    #2 spurious = 1;
    repeat (3) @(negedge clk);
    check("t5_err", err, 1'b1);
    e36 = 36'sd0; check("t5_inv_x_unchanged", inv_x, e36);
    send_ray(28'sd3, -28'sd1, 28'sd7, a);
    wait_out(oc);
    check("t5_latency", 64'(oc - a), 64'd12);
    e36 = 36'sd87381;   check("t5_inv_x", inv_x, e36);
    e36 = -36'sd262144; check("t5_inv_y", inv_y, e36);
    e36 = 36'sd37449;   check("t5_inv_z", inv_z, e36);
    check("t5_dz", dz_flags, 3'b000);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ray_inverse_sched.md
RAY_INVERSE_SCHED -- requirements
Module: ray_inverse_sched

Interface
REQ-001 Parameter DIVIDEND_ONE, default 18'sd1: constant signed numerator sent with every division (reciprocal numerator).
REQ-002 Parameter WAIT_MAX, default 64: cycles allowed between the last issue and the third result before timeout.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1; in_ready  output  1: ray-direction handshake, transfer when both high.
REQ-006 Port dir_x, dir_y, dir_z  input  28 each, signed  ray direction components.
REQ-007 Port div_clk_en  output  1  clock enable to the shared divider.
REQ-008 Port div_divisor_tvalid, div_dividend_tvalid  output  1  divider input strobes.
REQ-009 Port div_divisor  output  28 signed; div_dividend  output  18 signed  divider operands.
REQ-010 Port div_tvalid  input  1; div_by_zero  input  1; div_result  input  36 signed  divider output; no backpressure, in issue order.
REQ-011 Port out_valid  output  1; out_ready  input  1: result handshake.
REQ-012 Port inv_x, inv_y, inv_z  output  36 signed  reciprocals; dz_flags  output  3  per-axis divide-by-zero, bit0=x.
REQ-013 Port err  output  1  sticky protocol/timeout error.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, OUT; one ray in flight at a time.
REQ-015 in_ready = 1 only in IDLE; in IDLE, a handshake captures dir_x/y/z into internal registers and moves to ISSUE.
REQ-016 ISSUE lasts exactly 3 cycles: cycle k (k=0,1,2) drives both tvalids high with div_divisor = captured x, y, z respectively and div_dividend = DIVIDEND_ONE; then WAIT.
REQ-017 Both div tvalids low in every cycle outside ISSUE; div_divisor/div_dividend hold last values when not strobed.
REQ-018 div_clk_en = 1 in all states after reset; 0 during reset.
REQ-019 A 2-bit result counter stores each div_tvalid beat into inv_x, inv_y, inv_z in order; counting active in ISSUE and WAIT (results may arrive before issue completes).
REQ-020 When div_by_zero is high on a beat, the stored value is 36'sh7FFFFFFFF (max positive) and the matching dz_flags bit is set; otherwise div_result stored unchanged, flag clear.
REQ-021 On the third result beat, go to OUT; out_valid = 1 only in OUT.
REQ-022 OUT: inv_*/dz_flags stable while out_valid high and out_ready low; out_valid & out_ready -> IDLE; in_ready rises the following cycle (no same-cycle in/out overlap).
REQ-023 Latency: accept at cycle 0, issues cycles 1-3; out_valid asserts the cycle after the third div_tvalid (cycle 4+L for divider latency L).
REQ-024 WAIT timeout: 8-bit counter cleared on entry to WAIT and on each result beat; reaching WAIT_MAX sets err, fills missing axes with 0, and goes to OUT.
REQ-025 div_tvalid in IDLE or OUT is discarded and sets err; a fourth beat within a ray likewise.
REQ-026 err cleared only by reset.

Reset
REQ-027 rst_n low asynchronously forces IDLE, in_ready=0 while low (1 the first cycle after release), out_valid=0, both div tvalids=0, div_clk_en=0, div_divisor=0, div_dividend=0, inv_*=0, dz_flags=0, err=0, counters=0.
REQ-028 Reset mid-ray drops the ray; divider results arriving after release in IDLE set err per REQ-025 (integration must reset divider together).

Verification
REQ-029 dir=(2,4,-8) with L=8 model, out_ready=1 -> strobes cycles 1-3 with divisors 2,4,-8, out_valid cycle 12, inv = model results, dz_flags=0, err=0.
REQ-030 dir=(0,5,0) -> inv_x=inv_z=36'sh7FFFFFFFF, dz_flags=3'b101, inv_y = model result.
REQ-031 out_ready held low 10 cycles in OUT -> out_valid and inv_* constant, in_ready=0, no divider strobes.
REQ-032 Divider model drops the third result, WAIT_MAX=64 -> err=1 64 cycles after second beat, inv_z=0, out_valid=1.
REQ-033 Spurious div_tvalid in IDLE -> err=1, outputs unchanged; next ray still completes correctly.
REQ-034 rst_n pulsed low during WAIT -> all outputs at reset values immediately, in_ready=1 the cycle after release.
